// File: rtl/centroid_tracker_pkg.sv
// Shared types and widths for the centroid tracker and its divider.
package centroid_tracker_pkg;

  localparam int SUM_W = 32;  // x/y coordinate sum width
  localparam int CNT_W = 21;  // mask pixel count width
  localparam int X_W   = 11;  // centroid x width
  localparam int Y_W   = 10;  // centroid y width

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, W cycles total.
// The first step happens on the start edge itself, so done_o pulses W-1
// cycles after the start cycle. quotient_o holds until the next start.
module seq_divider
  import centroid_tracker_pkg::*;
#(
  parameter int W = SUM_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] quotient_o,
  output logic         done_o
);

  localparam int CW = $clog2(W) + 1;

  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [W-1:0]  src_rem_s, src_quo_s, src_dvs_s;
  logic [W:0]    shifted_s, diff_s;
  logic          qbit_s;

  // One restoring step on either the fresh operands or the running state.
  always_comb begin
    src_rem_s = start_i ? {W{1'b0}} : rem_q;
    src_quo_s = start_i ? dividend_i : quo_q;
    src_dvs_s = start_i ? divisor_i  : dvs_q;
    shifted_s = {src_rem_s, src_quo_s[W-1]};
    diff_s    = shifted_s - {1'b0, src_dvs_s};
    qbit_s    = (shifted_s >= {1'b0, src_dvs_s});

    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start_i) begin
      rem_d  = qbit_s ? diff_s[W-1:0] : shifted_s[W-1:0];
      quo_d  = {src_quo_s[W-2:0], qbit_s};
      dvs_d  = divisor_i;
      cnt_d  = CW'(1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = qbit_s ? diff_s[W-1:0] : shifted_s[W-1:0];
      quo_d = {src_quo_s[W-2:0], qbit_s};
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(W - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        busy_d = 1'b1;
      end
    end else begin
      busy_d = 1'b0;
    end
  end

  // Divider state register with synchronous reset (aborts any division).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q  <= {W{1'b0}};
      quo_q  <= {W{1'b0}};
      dvs_q  <= {W{1'b0}};
      cnt_q  <= {CW{1'b0}};
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign quotient_o = quo_q;
  assign done_o     = done_q;

endmodule

// File: rtl/centroid_tracker.sv
// Centroid tracker: accumulates mask pixel coordinates over a frame, divides
// by the pixel count at end of frame and drives a crosshair overlay bit.
// Optional macro CENTROID_MIN_PIXELS_EN: require at least MIN_PIXELS mask
// pixels before a new centroid is published.
module centroid_tracker
  import centroid_tracker_pkg::*;
#(
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720,
  parameter int MIN_PIXELS = 16
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic [X_W-1:0] hcount_in,
  input  logic [Y_W-1:0] vcount_in,
  input  logic           valid_in,
  input  logic           tabulate_in,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic           valid_out,
  output logic           crosshair_out
);

  localparam logic [X_W-1:0]   H_LIM = X_W'(H_ACTIVE);
  localparam logic [Y_W-1:0]   V_LIM = Y_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_PIXELS);

  state_e             state_q, state_d;
  logic               start_q, start_d;
  logic [SUM_W-1:0]   x_sum_q, x_sum_d, y_sum_q, y_sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SUM_W-1:0]   x_snap_q, x_snap_d, y_snap_q, y_snap_d;
  logic [CNT_W-1:0]   cnt_snap_q, cnt_snap_d;
  logic [X_W-1:0]     x_out_q, x_out_d;
  logic [Y_W-1:0]     y_out_q, y_out_d;
  logic               valid_q, valid_d;
  logic               cross_q, cross_d;

  logic               active_s, pix_ok_s, gate_s;
  logic [SUM_W-1:0]   x_acc_s, y_acc_s;
  logic [CNT_W-1:0]   cnt_acc_s;
  logic [SUM_W-1:0]   x_quo_s, y_quo_s;
  logic               x_done_s, y_done_s;
  logic               unused_quo_bits_s;

  // Running sums including this cycle's pixel; these feed both the
  // accumulators and the end-of-frame snapshot.
  always_comb begin
    active_s  = (hcount_in < H_LIM) && (vcount_in < V_LIM);
    pix_ok_s  = valid_in && active_s;
    x_acc_s   = x_sum_q + (pix_ok_s ? {{(SUM_W-X_W){1'b0}}, hcount_in} : {SUM_W{1'b0}});
    y_acc_s   = y_sum_q + (pix_ok_s ? {{(SUM_W-Y_W){1'b0}}, vcount_in} : {SUM_W{1'b0}});
    cnt_acc_s = cnt_q + {{(CNT_W-1){1'b0}}, pix_ok_s};
`ifdef CENTROID_MIN_PIXELS_EN
    gate_s = (cnt_acc_s >= MIN_CNT) && (cnt_acc_s != {CNT_W{1'b0}});
`else
    gate_s = (cnt_acc_s != {CNT_W{1'b0}});
`endif
  end

  // Accumulators keep running in every state; end of frame clears them.
  always_comb begin
    if (tabulate_in) begin
      x_sum_d = {SUM_W{1'b0}};
      y_sum_d = {SUM_W{1'b0}};
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      x_sum_d = x_acc_s;
      y_sum_d = y_acc_s;
      cnt_d   = cnt_acc_s;
    end
  end

  // Control FSM: snapshot on end of frame, wait for both dividers, publish.
  always_comb begin
    state_d    = state_q;
    start_d    = 1'b0;
    x_snap_d   = x_snap_q;
    y_snap_d   = y_snap_q;
    cnt_snap_d = cnt_snap_q;
    x_out_d    = x_out_q;
    y_out_d    = y_out_q;
    valid_d    = 1'b0;
    case (state_q)
      ACCUM: begin
        if (tabulate_in) begin
          x_snap_d   = x_acc_s;
          y_snap_d   = y_acc_s;
          cnt_snap_d = cnt_acc_s;
          if (gate_s) begin
            state_d = DIVIDE;
            start_d = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end else begin
          state_d = ACCUM;
        end
      end
      DIVIDE: begin
        if (x_done_s && y_done_s) begin
          state_d = DONE;
          x_out_d = x_quo_s[X_W-1:0];
          y_out_d = y_quo_s[Y_W-1:0];
          valid_d = 1'b1;
        end else begin
          state_d = DIVIDE;
        end
      end
      DONE: begin
        state_d = ACCUM;
      end
      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // Crosshair overlay: pixel lies on the published centroid row or column.
  always_comb begin
    if (active_s && ((hcount_in == x_out_q) || (vcount_in == y_out_q))) begin
      cross_d = 1'b1;
    end else begin
      cross_d = 1'b0;
    end
  end

  // State, accumulator, snapshot and output registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ACCUM;
      start_q    <= 1'b0;
      x_sum_q    <= {SUM_W{1'b0}};
      y_sum_q    <= {SUM_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      x_snap_q   <= {SUM_W{1'b0}};
      y_snap_q   <= {SUM_W{1'b0}};
      cnt_snap_q <= {CNT_W{1'b0}};
      x_out_q    <= {X_W{1'b0}};
      y_out_q    <= {Y_W{1'b0}};
      valid_q    <= 1'b0;
      cross_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      x_sum_q    <= x_sum_d;
      y_sum_q    <= y_sum_d;
      cnt_q      <= cnt_d;
      x_snap_q   <= x_snap_d;
      y_snap_q   <= y_snap_d;
      cnt_snap_q <= cnt_snap_d;
      x_out_q    <= x_out_d;
      y_out_q    <= y_out_d;
      valid_q    <= valid_d;
      cross_q    <= cross_d;
    end
  end

  seq_divider #(.W(SUM_W)) u_div_x (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .start_i    (start_q),
    .dividend_i (x_snap_q),
    .divisor_i  ({{(SUM_W-CNT_W){1'b0}}, cnt_snap_q}),
    .quotient_o (x_quo_s),
    .done_o     (x_done_s)
  );

  seq_divider #(.W(SUM_W)) u_div_y (
    .clk_i      (clk_in),
    .rst_i      (rst_in),
    .start_i    (start_q),
    .dividend_i (y_snap_q),
    .divisor_i  ({{(SUM_W-CNT_W){1'b0}}, cnt_snap_q}),
    .quotient_o (y_quo_s),
    .done_o     (y_done_s)
  );

  // Quotient bits above the coordinate widths are truncated by design.
  assign unused_quo_bits_s = ^{x_quo_s[SUM_W-1:X_W], y_quo_s[SUM_W-1:Y_W], MIN_CNT};

  assign x_out         = x_out_q;
  assign y_out         = y_out_q;
  assign valid_out     = valid_q;
  assign crosshair_out = cross_q;

endmodule

// File: tb/tb_centroid_tracker.sv
// Directed testbench for centroid_tracker (default build, count gate off).
module tb_centroid_tracker;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        valid_in;
  logic        tabulate_in;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic        valid_out;
  logic        crosshair_out;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  centroid_tracker dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .valid_in      (valid_in),
    .tabulate_in   (tabulate_in),
    .x_out         (x_out),
    .y_out         (y_out),
    .valid_out     (valid_out),
    .crosshair_out (crosshair_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Apply one cycle of inputs; returns 1 ns after the capturing edge.
  task automatic drive(input logic [10:0] h, input logic [9:0] v, input logic vld, input logic tab);
    hcount_in   = h;
    vcount_in   = v;
    valid_in    = vld;
    tabulate_in = tab;
    @(posedge clk_in);
    #1;
  endtask

  // End frame (optionally with a pixel in the same cycle), wait for result.
  task automatic tab_wait(input logic [10:0] h, input logic [9:0] v, input logic vld,
                          input logic [10:0] ex, input logic [9:0] ey, input string tag);
    int lat;
    drive(h, v, vld, 1'b1);
    lat = 1;
    while (!valid_out && lat < 60) begin
      drive(11'd0, 10'd0, 1'b0, 1'b0);
      lat++;
    end
    check({tag, "_latency"}, lat, 34);
    check({tag, "_x"}, x_out, ex);
    check({tag, "_y"}, y_out, ey);
    drive(11'd0, 10'd0, 1'b0, 1'b0);
    check({tag, "_pulse_len"}, valid_out, 1'b0);
  endtask

  initial begin
    int pulses;
    int first;
    rst_in = 1'b1;
    drive(11'd0, 10'd0, 1'b0, 1'b0);
    drive(11'd0, 10'd0, 1'b0, 1'b0);
    rst_in = 1'b0;
    check("rst_x", x_out, 0);
    check("rst_y", y_out, 0);
    check("rst_valid", valid_out, 0);
    check("rst_cross", crosshair_out, 0);

    // single pixel
    drive(11'd100, 10'd50, 1'b1, 1'b0);
    tab_wait(11'd0, 10'd0, 1'b0, 11'd100, 10'd50, "single");

    // three pixels, last one in the tabulate cycle
    drive(11'd10, 10'd10, 1'b1, 1'b0);
    drive(11'd20, 10'd10, 1'b1, 1'b0);
    tab_wait(11'd30, 10'd40, 1'b1, 11'd20, 10'd20, "three");

    // empty frame: no pulse, outputs hold
    pulses = 0;
    drive(11'd0, 10'd0, 1'b0, 1'b1);
    for (int c = 0; c < 40; c++) begin
      if (valid_out) pulses++;
      drive(11'd0, 10'd0, 1'b0, 1'b0);
    end
    check("empty_pulses", pulses, 0);
    check("empty_x_hold", x_out, 20);
    check("empty_y_hold", y_out, 20);

    // second tabulate during division is ignored and clears accumulators
    drive(11'd40, 10'd30, 1'b1, 1'b0);
    drive(11'd0, 10'd0, 1'b0, 1'b1);
    pulses = 0;
    first  = 0;
    for (int c = 1; c <= 80; c++) begin
      if (valid_out) begin
        pulses++;
        if (first == 0) first = c;
      end
      if (c == 5)       drive(11'd600, 10'd400, 1'b1, 1'b0);
      else if (c == 10) drive(11'd0, 10'd0, 1'b0, 1'b1);
      else              drive(11'd0, 10'd0, 1'b0, 1'b0);
    end
    check("retab_pulses", pulses, 1);
    check("retab_latency", first, 34);
    check("retab_x", x_out, 40);
    check("retab_y", y_out, 30);
    drive(11'd7, 10'd9, 1'b1, 1'b0);
    tab_wait(11'd0, 10'd0, 1'b0, 11'd7, 10'd9, "cleared");

    // out-of-range pixels ignored
    drive(11'd1280, 10'd5, 1'b1, 1'b0);
    drive(11'd3, 10'd720, 1'b1, 1'b0);
    drive(11'd4, 10'd6, 1'b1, 1'b0);
    tab_wait(11'd0, 10'd0, 1'b0, 11'd4, 10'd6, "range");

    // reset mid-division aborts it
    drive(11'd200, 10'd100, 1'b1, 1'b0);
    drive(11'd0, 10'd0, 1'b0, 1'b1);
    pulses = 0;
    for (int c = 1; c <= 50; c++) begin
      if (valid_out) pulses++;
      rst_in = (c == 15);
      drive(11'd0, 10'd0, 1'b0, 1'b0);
    end
    rst_in = 1'b0;
    check("abort_pulses", pulses, 0);
    check("abort_x", x_out, 0);
    check("abort_y", y_out, 0);
    drive(11'd30, 10'd60, 1'b1, 1'b0);
    tab_wait(11'd0, 10'd0, 1'b0, 11'd30, 10'd60, "after_abort");

    // reset wins over a same-cycle tabulate
    drive(11'd5, 10'd5, 1'b1, 1'b0);
    rst_in = 1'b1;
    drive(11'd0, 10'd0, 1'b0, 1'b1);
    rst_in = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (valid_out) pulses++;
      drive(11'd0, 10'd0, 1'b0, 1'b0);
    end
    check("rst_prio_pulses", pulses, 0);
    check("rst_prio_x", x_out, 0);

    // crosshair at (100,50)
    drive(11'd100, 10'd50, 1'b1, 1'b0);
    tab_wait(11'd0, 10'd0, 1'b0, 11'd100, 10'd50, "cross_setup");
    for (int v = 49; v <= 51; v++) begin
      for (int h = 95; h <= 105; h++) begin
        drive(11'(h), 10'(v), 1'b0, 1'b0);
        check($sformatf("cross_%0d_%0d", h, v), crosshair_out, ((h == 100) || (v == 50)) ? 1 : 0);
      end
    end
    drive(11'd0, 10'd50, 1'b0, 1'b0);
    check("cross_line_start", crosshair_out, 1);
    drive(11'd1279, 10'd50, 1'b0, 1'b0);
    check("cross_line_end", crosshair_out, 1);
    drive(11'd1280, 10'd50, 1'b0, 1'b0);
    check("cross_h_inactive", crosshair_out, 0);
    drive(11'd100, 10'd720, 1'b0, 1'b0);
    check("cross_v_inactive", crosshair_out, 0);
    drive(11'd100, 10'd700, 1'b0, 1'b0);
    check("cross_col_low", crosshair_out, 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
